// File: rtl/bpf_power_meter.sv
// bpf_power_meter: cascaded DF-I biquad band-pass on one time-multiplexed MAC with windowed power output.
module bpf_power_meter #(
  parameter int NSEC    = 2,
  parameter int IN_W    = 16,
  parameter int DATA_W  = 27,
  parameter int FRAC    = 23,
  parameter int OUT_W   = 14,
  parameter int OUT_LSB = 11,
  parameter int PWR_W   = 11,
  parameter int ACC_W   = 40
) (
  input  logic                     aud_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [IN_W-1:0]   in_aud,
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic signed [DATA_W-1:0] coef_wdata,
  input  logic [15:0]              win_len,
  input  logic [5:0]               pwr_shift,
  output logic                     coef_ready,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_aud,
  output logic [PWR_W-1:0]         power,
  output logic                     power_valid,
  output logic                     drop,
  output logic                     sat
);
  localparam int NC = 5 * NSEC;
  localparam int CB = $clog2(NC);
  localparam int SB = NSEC > 1 ? $clog2(NSEC) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 3;
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] UNITY = DATA_W'(1) <<< FRAC;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;
  logic signed [DATA_W-1:0] coef [NC];
  logic signed [DATA_W-1:0] x1 [NSEC], x2 [NSEC], y1 [NSEC], y2 [NSEC];
  logic signed [DATA_W-1:0] cur_x, op, ysat, neg_x;
  logic signed [OUT_W-1:0]  out_r, osat;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     mac, term, sum, sh;
  logic [DATA_W-1:0]        yo, mag;
  logic [CB-1:0]            ci;
  logic [SB-1:0]            sec;
  logic [2:0]               k;
  logic                     ovf, oovf, sat_acc, close;
  logic [ACC_W-1:0]         acc, acc_nx, pw;
  logic [ACC_W:0]           acc_sum;
  logic [PWR_W-1:0]         power_r, psat;
  logic [15:0]              cnt, cnt_nx, wl;
  wire accept = state == IDLE && in_valid && enable;
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept) state_nx = MAC;
    if (state == MAC && k == 3'd4 && sec == SB'(NSEC - 1)) state_nx = OUT;
    if (state == OUT) state_nx = IDLE;
  end
  always_ff @(posedge aud_clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // a1/a2 terms (k = 3, 4) are subtracted: a0 is an implicit 1.
  assign op   = k == 3'd0 ? cur_x : k == 3'd1 ? x1[sec] : k == 3'd2 ? x2[sec] : k == 3'd3 ? y1[sec] : y2[sec];
  assign prod = PW'(coef[ci]) * PW'(op);
  assign term = k >= 3'd3 ? -SW'(prod) : SW'(prod);
  assign sum  = mac + term;
  assign sh   = sum >>> FRAC;
  assign ovf  = !((&sh[SW-1:DATA_W-1]) || !(|sh[SW-1:DATA_W-1]));
  assign ysat = ovf ? (sh[SW-1] ? DMIN : DMAX) : sh[DATA_W-1:0];
  assign yo   = cur_x >>> OUT_LSB;
  assign oovf = !((&yo[DATA_W-1:OUT_W-1]) || !(|yo[DATA_W-1:OUT_W-1]));
  assign osat = oovf ? (yo[DATA_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}}) : yo[OUT_W-1:0];
  assign neg_x   = -cur_x;
  assign mag     = !cur_x[DATA_W-1] ? cur_x : neg_x[DATA_W-1] ? DMAX : neg_x;
  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(mag);
  assign acc_nx  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  assign pw      = acc_nx >> pwr_shift;
  assign psat    = |pw[ACC_W-1:PWR_W] ? '1 : pw[PWR_W-1:0];
  assign cnt_nx  = cnt + 16'd1;
  assign wl      = win_len == 16'd0 ? 16'd1 : win_len;
  assign close   = cnt_nx >= wl;
  assign coef_ready = state == IDLE;
  assign out_aud    = enable ? out_r : '0;
  assign power      = enable ? power_r : '0;
  always_ff @(posedge aud_clk) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) coef[i] <= i % 5 == 0 ? UNITY : '0;
      for (int i = 0; i < NSEC; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
      cur_x <= '0;
      mac <= '0;
      ci <= '0;
      sec <= '0;
      k <= '0;
      sat_acc <= 1'b0;
      acc <= '0;
      cnt <= '0;
      out_r <= '0;
      power_r <= '0;
      out_valid <= 1'b0;
      power_valid <= 1'b0;
      drop <= 1'b0;
      sat <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      power_valid <= 1'b0;
      sat <= 1'b0;
      drop <= in_valid && enable && state != IDLE;
      if (coef_we && state == IDLE && coef_addr < 6'(NC)) coef[coef_addr[CB-1:0]] <= coef_wdata;
      if (accept) begin
        cur_x <= {{(DATA_W-IN_W-8){in_aud[IN_W-1]}}, in_aud, 8'b0};
        mac <= '0;
        ci <= '0;
        sec <= '0;
        k <= '0;
        sat_acc <= 1'b0;
      end
      if (state == MAC) begin
        ci <= ci + 1'b1;
        if (k == 3'd4) begin
          k <= '0;
          mac <= '0;
          sec <= sec + 1'b1;
          x1[sec] <= cur_x;
          x2[sec] <= x1[sec];
          y1[sec] <= ysat;
          y2[sec] <= y1[sec];
          cur_x <= ysat;
          sat_acc <= sat_acc | ovf;
        end else begin
          k <= k + 1'b1;
          mac <= sum;
        end
      end
      if (state == OUT) begin
        out_valid <= 1'b1;
        out_r <= osat;
        sat <= sat_acc | oovf;
        acc <= close ? '0 : acc_nx;
        cnt <= close ? '0 : cnt_nx;
        if (close) begin
          power_r <= psat;
          power_valid <= 1'b1;
        end
      end
      if (!enable) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end
endmodule

// File: doc/bpf_power_meter.md
Name: bpf_power_meter

Overview:
- Parametrised successor to the fixed two-section band-pass/power block in the audio analysis chain.
- Runs a cascade of NSEC biquad sections on one time-multiplexed MAC, one coefficient per cycle.
- Coefficients are runtime-writable; the power window length and output scaling are runtime inputs.
- Sits between the audio codec sample stream and the visualiser bar logic; one instance per band.

Parameters:
- NSEC, 2, number of cascaded biquad sections (1..8).
- IN_W, 16, input sample width.
- DATA_W, 27, internal datapath and coefficient width, signed.
- FRAC, 23, coefficient fraction bits (1.0 = 0x800000).
- OUT_W, 14, out_aud width.
- OUT_LSB, 11, LSB of internal y taken for out_aud.
- PWR_W, 11, power output width.
- ACC_W, 40, power accumulator width.

Ports:
- aud_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  processing enable.
- in_valid  in  1  one-cycle sample strobe.
- in_aud  in  IN_W  signed sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  section*5 + idx; idx 0..4 = b0,b1,b2,a1,a2.
- coef_wdata  in  DATA_W  signed coefficient.
- win_len  in  16  samples per power window (0 treated as 1).
- pwr_shift  in  6  right shift applied to the accumulator.
- coef_ready  out  1  high in IDLE; writes accepted only then.
- out_valid  out  1  one-cycle pulse with out_aud.
- out_aud  out  OUT_W  filtered sample, signed.
- power  out  PWR_W  last window power, unsigned.
- power_valid  out  1  one-cycle pulse when power updates.
- drop  out  1  one-cycle pulse when in_valid is ignored because the block is busy.
- sat  out  1  one-cycle pulse when any section or out_aud saturates.

Behaviour:
- Reset:
  - All outputs 0 except coef_ready = 1.
  - Histories x1, x2, y1, y2 cleared; accumulator and window count cleared.
  - Each section set to pass-through: b0 = 0x800000, all other coefficients 0.
- Input alignment: x = sign_extend(in_aud) << 8, giving DATA_W bits.
- Section equation, direct form I, a0 implicit 1: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - Full-width products are summed, then arithmetically shifted right by FRAC.
  - The result saturates to DATA_W; saturation pulses sat.
- FSM:
  - IDLE: on in_valid & enable, latch x and go to MAC.
  - MAC: 5 cycles per section, one term per cycle. After the 5th term, the section result feeds the next section and that section's histories update. After section NSEC−1, go to OUT.
  - OUT: out_aud = sat_OUT_W(y >>> OUT_LSB). out_valid pulses. Power is updated. Go to IDLE.
- Latency: in_valid to out_valid = 5·NSEC + 2 cycles. Throughput is one sample per 5·NSEC + 2 cycles.
- in_valid outside IDLE: the sample is discarded, drop pulses, and the state is unchanged.
- in_valid and coef_we in the same IDLE cycle: the write takes effect first; the sample uses the new coefficient.
- coef_we outside IDLE, or coef_addr ≥ 5·NSEC: the write is ignored.
- Power path:
  - mag = |y|; the most negative value maps to the DATA_W maximum.
  - acc += mag, and count increments.
  - When count reaches win_len:
    - power = sat_PWR_W(acc >> pwr_shift); power_valid pulses.
    - acc and count clear.
  - The closing sample is included in its window, so every window holds exactly win_len samples.
- Accumulator overflow saturates to the ACC_W maximum.
- enable low:
  - An in-flight sample completes.
  - New in_valid is ignored without pulsing drop.
  - out_aud and power are forced to 0; acc and count are cleared.
  - Histories and coefficients are retained.
- Reset mid-operation returns the block to IDLE next cycle with reset values; no out_valid pulse.

Test Plan:
- Pass-through after reset, NSEC = 2: in_aud = 0x1000 → out_aud = 512 after 12 cycles; sat = 0.
- Section 0 loaded with b0 = 0x400000 and a1 = 0x7C00000 (−0.5). Impulse 0x4000 followed by zeros → out_aud = 1024, 512, 256.
- Power window, pass-through, win_len = 4, pwr_shift = 12, constant 0x1000 input → power = 1024, with power_valid on the 4th, 8th, … out_valid.
- Saturation: both sections b0 = 0x2000000 (4.0), in_aud = 0x7FFF → out_aud = 8191 and sat pulses; in_aud = 0x8000 → out_aud = −8192.
- Busy and write handling:
  - A second in_valid 3 cycles after the first → drop pulses and only one out_valid appears.
  - coef_we during MAC leaves the coefficient unchanged.
- Reset asserted mid-MAC → next cycle coef_ready = 1 and all outputs 0; the following sample gives a pass-through result.
